stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch counter chain (sec0/sec1/min0/min1 BCD counters plus lap registers). It turns one-cycle button events into registered count-enable, synchronous-clear and lap-latch commands. It also times an automatic lap-display release and saturates the watch at 59:59. It sits between the button debouncer/classifier and the stopwatch datapath, in the OneClk domain.

Parameters:
ACTIVE_MODE, 2'b11, mode value in which button events are accepted
LAP_HOLD, 5, OneClk ticks the lap display is held before auto-release; 0 = no auto-release
HOLD_W, 4, width of lap hold counter; LAP_HOLD must be < 2**HOLD_W

Ports:
OneClk  in  1  1 Hz tick clock; all state on posedge
rst  in  1  asynchronous reset, active-low
mode  in  2  current system mode
b0short  in  1  button0 short-press event, one OneClk cycle
b0long  in  1  button0 long-press level/event (lap qualifier)
b1short  in  1  button1 short-press event, one cycle
b1long  in  1  button1 long-press event, one cycle
at_max  in  1  datapath currently shows 59:59 (combinational from counters)
cnt_en  out  1  counter chain enable (registered)
cnt_clr  out  1  one-cycle synchronous clear of counters and lap registers
lap_latch  out  1  one-cycle strobe: capture counters into lap registers
lap_show  out  1  1 = display lap registers, 0 = live count
max_flag  out  1  sticky: watch saturated at 59:59
state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt_en=0, cnt_clr=0, lap_latch=0, lap_show=0, max_flag=0, hold counter=0.
- Event decode, only when mode==ACTIVE_MODE; otherwise all buttons are ignored and state is held:
  - CLR = b1long.
  - LAPEV = b1short & b0long.
  - SS = b1short & ~b0long.
  - Priority: CLR > at_max saturation > LAPEV > SS. b0short is unused by this block and is ignored.
- at_max is evaluated in every mode, so a background run still saturates.
- Transitions (next state registered on posedge OneClk):
  - Any state, CLR → IDLE. cnt_clr=1 for exactly the next cycle. max_flag cleared. Hold counter cleared.
  - IDLE: SS → RUN. LAPEV is ignored.
  - RUN:
    - at_max → PAUSE, max_flag set.
    - LAPEV → LAP: lap_latch=1 for one cycle, hold counter loads LAP_HOLD.
    - SS → PAUSE.
  - LAP (counters keep running, display frozen):
    - at_max → PAUSE, max_flag set, lap_show drops.
    - LAPEV → RUN (manual release).
    - SS → PAUSE.
    - If LAP_HOLD≠0, the hold counter decrements each cycle; at 1 → RUN on the next edge. Any button event on that same edge takes precedence.
  - PAUSE:
    - SS → RUN only if max_flag=0; otherwise stay in PAUSE.
    - LAPEV is ignored.
- Outputs:
  - cnt_en registered = (next state ∈ {RUN, LAP}); it is 0 on the same edge saturation is taken.
  - lap_show = (state==LAP).
  - lap_latch and cnt_clr are never high on the same cycle. A CLR on the cycle of a LAPEV suppresses lap_latch.
- Latency: one OneClk edge from event to state/output change. No combinational path from inputs to outputs except via registers.
- Leaving ACTIVE_MODE mid-run: RUN/LAP continue counting. The LAP hold timer continues and auto-releases.
- Reset during LAP or RUN: immediate IDLE with all outputs at reset values. No lap_latch or cnt_clr pulse is generated by reset.

Test Plan:
- Reset, mode=11, b1short pulse → state=01, cnt_en=1 next edge. Second b1short → state=10, cnt_en=0.
- RUN, b1short with b0long=1 → state=11, lap_latch=1 one cycle, lap_show=1. With no further input, returns to state=01 exactly 5 edges later, lap_show=0.
- RUN, at_max=1 → state=10, cnt_en=0, max_flag=1. Then b1short → stays 10. Then b1long → state=00, cnt_clr one cycle, max_flag=0.
- mode=01 with b1short/b1long/lap combos → no state change. While in RUN, at_max=1 still forces PAUSE.
- Same cycle b1long=1, b1short=1, b0long=1 in RUN → IDLE, cnt_clr=1, lap_latch=0.
- rst=0 asserted mid-LAP between clock edges → outputs zero immediately. After release, first b1short → RUN.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button events and datapath status in, counter-chain commands out
interface stopwatch_ctrl_if;
  logic [1:0] mode;
  logic       b0short;
  logic       b0long;
  logic       b1short;
  logic       b1long;
  logic       at_max;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_latch;
  logic       lap_show;
  logic       max_flag;
  logic [1:0] state;
  modport master (
    output mode, b0short, b0long, b1short, b1long, at_max,
    input  cnt_en, cnt_clr, lap_latch, lap_show, max_flag, state
  );
  modport slave (
    input  mode, b0short, b0long, b1short, b1long, at_max,
    output cnt_en, cnt_clr, lap_latch, lap_show, max_flag, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: turns button events into registered run/clear/lap commands with lap auto-release and 59:59 saturation
module stopwatch_ctrl #(
  parameter logic [1:0] ACTIVE_MODE = 2'b11,
  parameter int         LAP_HOLD    = 5,
  parameter int         HOLD_W      = 4
) (
  input logic           OneClk,
  input logic           rst,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} st_t;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LAP_HOLD);
  st_t               cur, nxt;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic              cnt_en, cnt_clr, lap_latch, max_flag;
  logic              max_nx, latch_nx;
  logic              act, clr, lapev, ss, sat;
  logic              unused;
  assign unused = bus.b0short;
  assign act    = bus.mode == ACTIVE_MODE;
  assign clr    = act & bus.b1long;
  assign lapev  = act & bus.b1short & bus.b0long;
  assign ss     = act & bus.b1short & ~bus.b0long;
  // saturation is only meaningful while the chain is counting, whatever the mode
  assign sat    = bus.at_max & (cur == RUN || cur == LAP);
  always_comb begin
    nxt      = cur;
    max_nx   = max_flag;
    hold_nx  = '0;
    latch_nx = 1'b0;
    if (clr) begin
      nxt    = IDLE;
      max_nx = 1'b0;
    end else if (sat) begin
      nxt    = PAUSE;
      max_nx = 1'b1;
    end else begin
      case (cur)
        IDLE:  nxt = ss ? RUN : IDLE;
        RUN: begin
          if (lapev) begin
            nxt      = LAP;
            latch_nx = 1'b1;
            hold_nx  = HOLD_INIT;
          end else if (ss) nxt = PAUSE;
        end
        LAP: begin
          if (lapev) nxt = RUN;
          else if (ss) nxt = PAUSE;
          else if (hold == HOLD_W'(1)) nxt = RUN;
          else hold_nx = (hold != '0) ? hold - HOLD_W'(1) : '0;
        end
        PAUSE: nxt = (ss && !max_flag) ? RUN : PAUSE;
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge OneClk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      hold      <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      lap_latch <= 1'b0;
      max_flag  <= 1'b0;
    end else begin
      cur       <= nxt;
      hold      <= hold_nx;
      cnt_en    <= (nxt == RUN) || (nxt == LAP);
      cnt_clr   <= clr;
      lap_latch <= latch_nx;
      max_flag  <= max_nx;
    end
  end
  assign bus.state     = cur;
  assign bus.cnt_en    = cnt_en;
  assign bus.cnt_clr   = cnt_clr;
  assign bus.lap_latch = lap_latch;
  assign bus.lap_show  = cur == LAP;
  assign bus.max_flag  = max_flag;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  logic OneClk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;
  exp_t q[$];
  stopwatch_ctrl_if bus();
  stopwatch_ctrl dut (.OneClk(OneClk), .rst(rst), .bus(bus.slave));
  always #5 OneClk = ~OneClk;
  function automatic logic [6:0] E(logic [1:0] s, logic en, logic clr, logic lat, logic show, logic mx);
    return {s, en, clr, lat, show, mx};
  endfunction
  function automatic logic [6:0] obs();
    return {bus.state, bus.cnt_en, bus.cnt_clr, bus.lap_latch, bus.lap_show, bus.max_flag};
  endfunction
  task automatic check(string tag, logic [6:0] got, logic [6:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %b want %b (state,en,clr,latch,show,max)", tag, got, want);
    end
  endtask
  task automatic step(string tag, logic [1:0] m, logic b1s, logic b1l, logic b0l, logic am, logic [6:0] want);
    exp_t e;
    @(negedge OneClk);
    bus.mode    = m;
    bus.b1short = b1s;
    bus.b1long  = b1l;
    bus.b0long  = b0l;
    bus.at_max  = am;
    bus.b0short = 1'($urandom_range(0, 1));
    q.push_back('{tag, want});
    @(posedge OneClk);
    #1;
    e = q.pop_front();
    check(e.tag, obs(), e.v);
  endtask
  initial begin
    bus.mode = 2'b11; bus.b0short = 0; bus.b0long = 0;
    bus.b1short = 0; bus.b1long = 0; bus.at_max = 0;
    #1 rst = 1'b0;
    #2 check("reset", obs(), E(0,0,0,0,0,0));
    @(negedge OneClk) rst = 1'b1;
    step("ss_run",    3, 1,0,0,0, E(1,1,0,0,0,0));
    step("run_hold",  3, 0,0,0,0, E(1,1,0,0,0,0));
    step("ss_pause",  3, 1,0,0,0, E(2,0,0,0,0,0));
    step("ss_resume", 3, 1,0,0,0, E(1,1,0,0,0,0));
    step("lap_enter", 3, 1,0,1,0, E(3,1,0,1,1,0));
    for (int i = 0; i < 4; i++) step("lap_hold", 3, 0,0,0,0, E(3,1,0,0,1,0));
    step("lap_auto",  3, 0,0,0,0, E(1,1,0,0,0,0));
    step("lap_enter2",3, 1,0,1,0, E(3,1,0,1,1,0));
    step("lap_manual",3, 1,0,1,0, E(1,1,0,0,0,0));
    step("lap_enter3",3, 1,0,1,0, E(3,1,0,1,1,0));
    for (int i = 0; i < 4; i++) step("lap_hold3", 3, 0,0,0,0, E(3,1,0,0,1,0));
    step("lap_ss_on_release", 3, 1,0,0,0, E(2,0,0,0,0,0));
    step("resume2",   3, 1,0,0,0, E(1,1,0,0,0,0));
    step("sat_run",   3, 0,0,0,1, E(2,0,0,0,0,1));
    step("sat_ss_blk",3, 1,0,0,1, E(2,0,0,0,0,1));
    step("clr_pause", 3, 0,1,0,1, E(0,0,1,0,0,0));
    step("clr_pulse", 3, 0,0,0,0, E(0,0,0,0,0,0));
    step("idle_lapev",3, 1,0,1,0, E(0,0,0,0,0,0));
    step("run3",      3, 1,0,0,0, E(1,1,0,0,0,0));
    step("lap4",      3, 1,0,1,0, E(3,1,0,1,1,0));
    step("sat_lap",   3, 0,0,0,1, E(2,0,0,0,0,1));
    step("clr2",      3, 0,1,0,0, E(0,0,1,0,0,0));
    step("m1_idle_ss",1, 1,0,0,0, E(0,0,0,0,0,0));
    step("run4",      3, 1,0,0,0, E(1,1,0,0,0,0));
    step("m1_ss",     1, 1,0,0,0, E(1,1,0,0,0,0));
    step("m1_clr",    1, 0,1,0,0, E(1,1,0,0,0,0));
    step("m1_lapev",  1, 1,0,1,0, E(1,1,0,0,0,0));
    step("m1_sat",    1, 1,1,1,1, E(2,0,0,0,0,1));
    step("clr3",      3, 0,1,0,0, E(0,0,1,0,0,0));
    step("run5",      3, 1,0,0,0, E(1,1,0,0,0,0));
    step("lap5",      3, 1,0,1,0, E(3,1,0,1,1,0));
    for (int i = 0; i < 4; i++) step("m1_lap_hold", 1, 1,0,0,0, E(3,1,0,0,1,0));
    step("m1_lap_auto",1, 1,0,1,0, E(1,1,0,0,0,0));
    step("combo_clr", 3, 1,1,1,0, E(0,0,1,0,0,0));
    step("run6",      3, 1,0,0,0, E(1,1,0,0,0,0));
    step("lap6",      3, 1,0,1,0, E(3,1,0,1,1,0));
    #2 rst = 1'b0;
    #1 check("async_rst", obs(), E(0,0,0,0,0,0));
    @(negedge OneClk) rst = 1'b1;
    step("post_rst",  3, 0,0,0,0, E(0,0,0,0,0,0));
    step("post_run",  3, 1,0,0,0, E(1,1,0,0,0,0));
    check("queue_empty", 7'(q.size()), 7'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
